// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared types and constants for the IFU/LSU AXI arbiter.
package ysyx_24100006_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrantIfuAr,
        StGrantLsuAr,
        StGrantLsuAw,
        StData
    } arb_state_e;

    localparam logic [1:0] RespOkay = 2'b00;
    localparam logic       OwnIfu   = 1'b0;
    localparam logic       OwnLsu   = 1'b1;
    localparam int unsigned LenW    = 8;
    localparam int unsigned SizeW   = 3;

    // IFU wins when it is alone, or on a tie when the LSU held the last grant.
    function automatic logic rr_pick_ifu(logic ifu_req, logic lsu_req, logic rr_last);
        return ifu_req & (~lsu_req | (rr_last == OwnLsu));
    endfunction

endpackage

// File: rtl/ysyx_24100006_axi_req_latch.sv
// Address/len/size capture register for one AXI address channel; loaded on grant,
// held until the next grant.
module ysyx_24100006_axi_req_latch
    import ysyx_24100006_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LenW-1:0]   len_i,
    input  logic [SizeW-1:0]  size_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LenW-1:0]   len_o,
    output logic [SizeW-1:0]  size_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [LenW-1:0]   len_q;
    logic [SizeW-1:0]  size_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            len_q  <= len_i;
            size_q <= size_i;
        end
    end

    assign addr_o = addr_q;
    assign len_o  = len_q;
    assign size_o = size_q;

endmodule

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 arbiter. One transaction in flight at a time;
// the granted request is held stable until it retires because the xbar decodes from it.
module ysyx_24100006_axi_arbiter
    import ysyx_24100006_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // IFU read
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rlast,
    // LSU read
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rlast,
    // LSU write
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,
    // xbar-side master port
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    output logic [1:0]          m_addr_suffix
);

    arb_state_e state_q, state_d;
    logic       rr_last_q;
    logic       owner_q;
    logic       is_write_q;
    logic       w_done_q;

    logic arb_en, ifu_wins;
    logic grant_ifu, grant_lsu_ar, grant_lsu_aw, grant_ar, any_grant;
    logic in_data, rd_route, wr_phase, b_route, to_ifu, to_lsu;
    logic w_fire;

    // Gated by reset so no upstream ready escapes while reset is held.
    assign arb_en       = (state_q == StIdle) & ~reset;
    assign ifu_wins     = rr_pick_ifu(ifu_arvalid, lsu_arvalid | lsu_awvalid, rr_last_q);
    assign grant_ifu    = arb_en & ifu_wins;
    assign grant_lsu_aw = arb_en & ~ifu_wins & lsu_awvalid;
    assign grant_lsu_ar = arb_en & ~ifu_wins & ~lsu_awvalid & lsu_arvalid;
    assign grant_ar     = grant_ifu | grant_lsu_ar;
    assign any_grant    = grant_ar | grant_lsu_aw;

    assign ifu_arready  = grant_ifu;
    assign lsu_arready  = grant_lsu_ar;
    assign lsu_awready  = grant_lsu_aw;

    ysyx_24100006_axi_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_ar_latch (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (grant_ar),
        .addr_i  (grant_ifu ? ifu_araddr : lsu_araddr),
        .len_i   (grant_ifu ? ifu_arlen  : lsu_arlen),
        .size_i  (grant_ifu ? ifu_arsize : lsu_arsize),
        .addr_o  (m_araddr),
        .len_o   (m_arlen),
        .size_o  (m_arsize)
    );

    ysyx_24100006_axi_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_aw_latch (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (grant_lsu_aw),
        .addr_i  (lsu_awaddr),
        .len_i   (lsu_awlen),
        .size_i  (lsu_awsize),
        .addr_o  (m_awaddr),
        .len_o   (m_awlen),
        .size_o  (m_awsize)
    );

    assign m_addr_suffix = m_araddr[1:0];
    assign m_arvalid     = (state_q == StGrantIfuAr) | (state_q == StGrantLsuAr);
    assign m_awvalid     = (state_q == StGrantLsuAw);

    assign in_data  = (state_q == StData);
    assign rd_route = in_data & ~is_write_q;
    assign wr_phase = (state_q == StGrantLsuAw) | (in_data & is_write_q);
    // B is only exposed once both the AW and the last W beat have completed.
    assign b_route  = in_data & is_write_q & w_done_q;
    assign to_ifu   = rd_route & (owner_q == OwnIfu);
    assign to_lsu   = rd_route & (owner_q == OwnLsu);

    assign m_rready   = (to_ifu & ifu_rready) | (to_lsu & lsu_rready);
    assign ifu_rvalid = to_ifu & m_rvalid;
    assign ifu_rdata  = m_rdata;
    assign ifu_rresp  = to_ifu ? m_rresp : RespOkay;
    assign ifu_rlast  = to_ifu & m_rlast;
    assign lsu_rvalid = to_lsu & m_rvalid;
    assign lsu_rdata  = m_rdata;
    assign lsu_rresp  = to_lsu ? m_rresp : RespOkay;
    assign lsu_rlast  = to_lsu & m_rlast;

    assign m_wvalid   = wr_phase & lsu_wvalid;
    assign lsu_wready = wr_phase & m_wready;
    assign m_wdata    = lsu_wdata;
    assign m_wstrb    = lsu_wstrb;
    assign m_wlast    = lsu_wlast;
    assign w_fire     = m_wvalid & lsu_wready & lsu_wlast;

    assign lsu_bvalid = b_route & m_bvalid;
    assign m_bready   = b_route & lsu_bready;
    assign lsu_bresp  = b_route ? m_bresp : RespOkay;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_ifu)         state_d = StGrantIfuAr;
                else if (grant_lsu_aw) state_d = StGrantLsuAw;
                else if (grant_lsu_ar) state_d = StGrantLsuAr;
            end
            StGrantIfuAr, StGrantLsuAr: begin
                if (m_arready) state_d = StData;
            end
            StGrantLsuAw: begin
                if (m_awready) state_d = StData;
            end
            StData: begin
                if (is_write_q ? (lsu_bvalid & m_bready) : (m_rvalid & m_rready & m_rlast)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_last_q  <= OwnIfu;
            owner_q    <= OwnIfu;
            is_write_q <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (any_grant) begin
                rr_last_q  <= grant_ifu ? OwnIfu : OwnLsu;
                owner_q    <= grant_ifu ? OwnIfu : OwnLsu;
                is_write_q <= grant_lsu_aw;
            end
            if (grant_lsu_aw)  w_done_q <= 1'b0;
            else if (w_fire)   w_done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed self-checking bench for the IFU/LSU AXI arbiter; inputs change and outputs are
// sampled around the falling clock edge.
module tb_ysyx_24100006_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0] m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_addr_suffix;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ysyx_24100006_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rlast(lsu_rlast),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wlast(lsu_wlast), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .lsu_bresp(lsu_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bresp(m_bresp), .m_addr_suffix(m_addr_suffix)
    );

    task clear_inputs();
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_rready = 1;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_rready = 1;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_awlen = 0; lsu_awsize = 0;
        lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0; lsu_bready = 1;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    endtask

    task test_reset();
        reset = 1; clear_inputs();
        ifu_arvalid = 1; lsu_awvalid = 1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({ifu_arready, lsu_arready, lsu_awready} !== 3'b000) begin fails++;
            $display("FAIL rst_upready got %b exp 000", {ifu_arready, lsu_arready, lsu_awready}); end
        tests++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin fails++;
            $display("FAIL rst_mvalid got %b exp 00000", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}); end
        tests++; if ({m_araddr, m_awaddr, m_addr_suffix} !== 66'h0) begin fails++;
            $display("FAIL rst_latch got %h %h %b exp 0", m_araddr, m_awaddr, m_addr_suffix); end
        ifu_arvalid = 0; lsu_awvalid = 0;
        @(negedge clk); reset = 0;
        @(negedge clk);
    endtask

    task test_ifu_single();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0004; ifu_arlen = 0; ifu_arsize = 2;
        #1;
        tests++; if (ifu_arready !== 1'b1 || m_arvalid !== 1'b0) begin fails++;
            $display("FAIL t1_grant got rdy=%b mval=%b exp 1 0", ifu_arready, m_arvalid); end
        @(negedge clk); ifu_arvalid = 0; ifu_araddr = 0;
        #1;
        tests++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0004 || m_arsize !== 3'd2) begin fails++;
            $display("FAIL t1_mar got v=%b a=%h s=%0d exp 1 80000004 2", m_arvalid, m_araddr, m_arsize); end
        tests++; if (m_addr_suffix !== 2'b00 || ifu_arready !== 1'b0) begin fails++;
            $display("FAIL t1_suffix got %b rdy=%b exp 00 0", m_addr_suffix, ifu_arready); end
        m_arready = 1;
        @(negedge clk); m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h1234; m_rlast = 1;
        #1;
        tests++; if (m_arvalid !== 1'b0) begin fails++;
            $display("FAIL t1_ardrop got %b exp 0", m_arvalid); end
        tests++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h1234 || lsu_rvalid !== 1'b0 || m_rready !== 1'b1) begin fails++;
            $display("FAIL t1_rdata got v=%b d=%h lv=%b rr=%b exp 1 1234 0 1", ifu_rvalid, ifu_rdata, lsu_rvalid, m_rready); end
        @(negedge clk); m_rvalid = 0; m_rlast = 0;
        #1;
        tests++; if (m_rready !== 1'b0) begin fails++;
            $display("FAIL t1_idle got rready=%b exp 0", m_rready); end
    endtask

    task test_rr_tie();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; ifu_arsize = 2;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0200; lsu_arsize = 2;
        #1;
        tests++; if (lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin fails++;
            $display("FAIL t2_tie1 got lsu=%b ifu=%b exp 1 0", lsu_arready, ifu_arready); end
        @(negedge clk); lsu_arvalid = 0;
        #1;
        tests++; if (m_araddr !== 32'h8000_0200 || ifu_arready !== 1'b0) begin fails++;
            $display("FAIL t2_lsuaddr got %h rdy=%b exp 80000200 0", m_araddr, ifu_arready); end
        m_arready = 1;
        @(negedge clk); m_arready = 0;
        m_rvalid = 1; m_rdata = 32'hbeef; m_rlast = 1;
        #1;
        tests++; if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0 || lsu_rdata !== 32'hbeef || ifu_arready !== 1'b0) begin fails++;
            $display("FAIL t2_lsur got lv=%b iv=%b d=%h irdy=%b exp 1 0 beef 0", lsu_rvalid, ifu_rvalid, lsu_rdata, ifu_arready); end
        @(negedge clk); m_rvalid = 0; m_rlast = 0;
        #1;
        tests++; if (ifu_arready !== 1'b1 || m_arvalid !== 1'b0) begin fails++;
            $display("FAIL t2_ifugrant got rdy=%b mv=%b exp 1 0", ifu_arready, m_arvalid); end
        @(negedge clk); ifu_arvalid = 0;
        #1;
        tests++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0100) begin fails++;
            $display("FAIL t2_ifuaddr got v=%b a=%h exp 1 80000100", m_arvalid, m_araddr); end
        m_arready = 1;
        @(negedge clk); m_arready = 0; m_rvalid = 1; m_rlast = 1;
        @(negedge clk); m_rvalid = 0; m_rlast = 0;
    endtask

    task test_lsu_write_first();
        lsu_awvalid = 1; lsu_awaddr = 32'ha000_03f8; lsu_awsize = 0;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0010; lsu_arsize = 2;
        lsu_wvalid = 1; lsu_wdata = 32'h41; lsu_wstrb = 4'b0001; lsu_wlast = 1;
        m_wready = 1;
        #1;
        tests++; if (lsu_awready !== 1'b1 || lsu_arready !== 1'b0 || lsu_wready !== 1'b0 || m_wvalid !== 1'b0) begin fails++;
            $display("FAIL t3_awfirst got aw=%b ar=%b wr=%b wv=%b exp 1 0 0 0", lsu_awready, lsu_arready, lsu_wready, m_wvalid); end
        @(negedge clk); lsu_awvalid = 0;
        #1;
        tests++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'ha000_03f8 || m_arvalid !== 1'b0) begin fails++;
            $display("FAIL t3_maw got v=%b a=%h arv=%b exp 1 a00003f8 0", m_awvalid, m_awaddr, m_arvalid); end
        tests++; if (m_wvalid !== 1'b1 || m_wdata !== 32'h41 || m_wstrb !== 4'b0001 || m_wlast !== 1'b1 || lsu_wready !== 1'b1) begin fails++;
            $display("FAIL t3_wfwd got v=%b d=%h s=%b l=%b rdy=%b exp 1 41 0001 1 1", m_wvalid, m_wdata, m_wstrb, m_wlast, lsu_wready); end
        m_awready = 1;
        @(negedge clk); m_awready = 0; lsu_wvalid = 0; m_wready = 0; m_bvalid = 1;
        #1;
        tests++; if (lsu_bvalid !== 1'b1 || m_bready !== 1'b1 || m_awvalid !== 1'b0 || lsu_arready !== 1'b0) begin fails++;
            $display("FAIL t3_b got bv=%b br=%b awv=%b ar=%b exp 1 1 0 0", lsu_bvalid, m_bready, m_awvalid, lsu_arready); end
        @(negedge clk); m_bvalid = 0;
        #1;
        tests++; if (lsu_arready !== 1'b1) begin fails++;
            $display("FAIL t3_readnext got %b exp 1", lsu_arready); end
        @(negedge clk); lsu_arvalid = 0;
        #1;
        tests++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0010) begin fails++;
            $display("FAIL t3_mar got v=%b a=%h exp 1 80000010", m_arvalid, m_araddr); end
        m_arready = 1;
        @(negedge clk); m_arready = 0; m_rvalid = 1; m_rlast = 1;
        @(negedge clk); m_rvalid = 0; m_rlast = 0;
    endtask

    task test_rr_ifu_wins();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0300;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0400;
        #1;
        tests++; if (ifu_arready !== 1'b1 || lsu_arready !== 1'b0) begin fails++;
            $display("FAIL t4_tie2 got ifu=%b lsu=%b exp 1 0", ifu_arready, lsu_arready); end
        @(negedge clk); ifu_arvalid = 0; lsu_arvalid = 0;
        m_arready = 1;
        @(negedge clk); m_arready = 0; m_rvalid = 1; m_rlast = 1;
        #1;
        tests++; if (ifu_rvalid !== 1'b1 || lsu_rvalid !== 1'b0) begin fails++;
            $display("FAIL t4_route got ifu=%b lsu=%b exp 1 0", ifu_rvalid, lsu_rvalid); end
        @(negedge clk); m_rvalid = 0; m_rlast = 0;
    endtask

    task test_lsu_lb_error();
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0003; lsu_arsize = 0;
        @(negedge clk); lsu_arvalid = 0; lsu_araddr = 0;
        #1;
        tests++; if (m_addr_suffix !== 2'b11 || m_arsize !== 3'd0) begin fails++;
            $display("FAIL t5_suffix got %b size=%0d exp 11 0", m_addr_suffix, m_arsize); end
        m_arready = 1;
        @(negedge clk); m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rresp = 2'b10;
        #1;
        tests++; if (lsu_rresp !== 2'b10 || lsu_rvalid !== 1'b1 || m_addr_suffix !== 2'b11) begin fails++;
            $display("FAIL t5_err got resp=%b v=%b suf=%b exp 10 1 11", lsu_rresp, lsu_rvalid, m_addr_suffix); end
        @(negedge clk); m_rvalid = 0; m_rlast = 0; m_rresp = 0;
        #1;
        tests++; if (m_rready !== 1'b0) begin fails++;
            $display("FAIL t5_idle got rready=%b exp 0", m_rready); end
    endtask

    task test_w_after_aw();
        lsu_awvalid = 1; lsu_awaddr = 32'ha000_0010; lsu_awsize = 2;
        @(negedge clk); lsu_awvalid = 0; m_awready = 1;
        @(negedge clk); m_awready = 0; m_bvalid = 1; m_bresp = 2'b10;
        #1;
        tests++; if (lsu_bvalid !== 1'b0 || m_bready !== 1'b0) begin fails++;
            $display("FAIL t6_bblock got bv=%b br=%b exp 0 0", lsu_bvalid, m_bready); end
        lsu_wvalid = 1; lsu_wdata = 32'h55; lsu_wstrb = 4'hf; lsu_wlast = 1; m_wready = 1;
        #1;
        tests++; if (m_wvalid !== 1'b1 || lsu_wready !== 1'b1) begin fails++;
            $display("FAIL t6_wlate got wv=%b wr=%b exp 1 1", m_wvalid, lsu_wready); end
        @(negedge clk); lsu_wvalid = 0; m_wready = 0;
        #1;
        tests++; if (lsu_bvalid !== 1'b1 || m_bready !== 1'b1 || lsu_bresp !== 2'b10) begin fails++;
            $display("FAIL t6_b got bv=%b br=%b resp=%b exp 1 1 10", lsu_bvalid, m_bready, lsu_bresp); end
        @(negedge clk); m_bvalid = 0; m_bresp = 0;
    endtask

    task test_burst();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_1000; ifu_arlen = 3; ifu_arsize = 2;
        @(negedge clk); ifu_arvalid = 0; ifu_araddr = 0;
        #1;
        tests++; if (m_arlen !== 8'd3) begin fails++;
            $display("FAIL t7_len got %0d exp 3", m_arlen); end
        m_arready = 1;
        @(negedge clk); m_arready = 0;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1; m_rdata = 32'h100 + i; m_rlast = (i == 3);
            #1;
            tests++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h100 + i || ifu_rlast !== (i == 3)
                         || m_rready !== 1'b1 || m_araddr !== 32'h8000_1000) begin fails++;
                $display("FAIL t7_beat%0d got v=%b d=%h l=%b rr=%b a=%h", i, ifu_rvalid, ifu_rdata,
                         ifu_rlast, m_rready, m_araddr); end
            @(negedge clk);
        end
        m_rvalid = 0; m_rlast = 0;
        #1;
        tests++; if (m_rready !== 1'b0) begin fails++;
            $display("FAIL t7_done got rready=%b exp 0", m_rready); end
    endtask

    task test_reset_mid();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_2000; ifu_arlen = 3;
        @(negedge clk); ifu_arvalid = 0; m_arready = 1;
        @(negedge clk); m_arready = 0; m_rvalid = 1; m_rdata = 32'h7;
        @(negedge clk);
        reset = 1; ifu_arvalid = 1;
        #1;
        tests++; if ({ifu_rvalid, m_rready, m_arvalid, ifu_arready, lsu_arready, lsu_awready} !== 6'b0) begin fails++;
            $display("FAIL t8_rst got %b exp 000000", {ifu_rvalid, m_rready, m_arvalid, ifu_arready, lsu_arready, lsu_awready}); end
        tests++; if (m_araddr !== 32'h0) begin fails++;
            $display("FAIL t8_rstaddr got %h exp 0", m_araddr); end
        @(negedge clk); reset = 0; ifu_arvalid = 0; m_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (m_arvalid !== 1'b0 || ifu_arready !== 1'b0) begin fails++;
                $display("FAIL t8_quiet%0d got mv=%b rdy=%b exp 0 0", i, m_arvalid, ifu_arready); end
            @(negedge clk);
        end
        ifu_arvalid = 1; ifu_arlen = 0;
        #1;
        tests++; if (ifu_arready !== 1'b1) begin fails++;
            $display("FAIL t8_newreq got %b exp 1", ifu_arready); end
        @(negedge clk); ifu_arvalid = 0;
        #1;
        tests++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_2000) begin fails++;
            $display("FAIL t8_mar got v=%b a=%h exp 1 80002000", m_arvalid, m_araddr); end
    endtask

    initial begin
        test_reset();
        test_ifu_single();
        test_rr_tie();
        test_lsu_write_first();
        test_rr_ifu_wins();
        test_lsu_lb_error();
        test_w_after_aw();
        test_burst();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
